// File: rtl/saw_tx_ctrl.sv
// Stop-and-wait ARQ sender: issues one payload at a time with an alternating sequence bit,
// then retransmits on NAK or timeout until it is acknowledged or the retry budget runs out.
module saw_tx_ctrl #(
  parameter int BW        = 40,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 req_valid,
  output logic                                                 req_ready,
  input  logic [BW-1:0]                                        req_data,
  output logic                                                 tx_valid,
  output logic [BW-1:0]                                        tx_payload,
  output logic                                                 tx_seq,
  input  logic                                                 ack_valid,
  input  logic                                                 ack_nak,
  input  logic                                                 ack_seq,
  output logic                                                 done,
  output logic                                                 fail,
  output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1)-1:0] retry_cnt
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;

  logic accept;
  logic ack_hit;
  logic nak_hit;
  logic timeout_hit;
  logic retry_ev;
  logic can_retry;

  // An ACK wins over a coincident timeout; a NAK plus timeout collapses into one retry.
  always_comb begin
    accept      = (state == IDLE) && req_valid;
    ack_hit     = (state == WAIT) && ack_valid && !ack_nak && (ack_seq == tx_seq);
    nak_hit     = (state == WAIT) && ack_valid &&  ack_nak && (ack_seq == tx_seq);
    timeout_hit = (state == WAIT) && (timer == TW'(TIMEOUT - 1));
    retry_ev    = !ack_hit && (nak_hit || timeout_hit);
    can_retry   = (retry_cnt < RW'(MAX_RETRY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ack_hit) begin
          state_nxt = IDLE;
        end else if (retry_ev) begin
          state_nxt = can_retry ? SEND : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !rst;
    tx_valid  = (state == SEND);
  end

  // Frame bookkeeping; retry_cnt is left alone in IDLE so the last frame's count stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_payload <= '0;
      tx_seq     <= 1'b0;
      retry_cnt  <= '0;
      timer      <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      done <= ack_hit;
      fail <= retry_ev && !can_retry;
      if (accept) begin
        tx_payload <= req_data;
        retry_cnt  <= '0;
      end else if (retry_ev && can_retry) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (ack_hit) begin
        tx_seq <= ~tx_seq;
      end
      if (state == SEND) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end
    end
  end

  a_strobes_exclusive : assert property (@(posedge clk) disable iff (rst)
    $onehot0({done, fail, tx_valid}));

  a_retry_bounded : assert property (@(posedge clk) disable iff (rst)
    retry_cnt <= RW'(MAX_RETRY));

endmodule
